// File: rtl/buffer_pkg.sv
// Shared types and sizing for the shift_buffer / shift_unbuffer pair.
package buffer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WORDS  = 8;
  localparam int unsigned VEC_W  = DATA_W * WORDS;
  localparam int unsigned CNT_W  = $clog2(WORDS);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [VEC_W-1:0]  vec_t;

  typedef enum logic {IDLE, SEND} unbuf_state_e;

endpackage

// File: rtl/shift_unbuffer_if.sv
// Wide-in / serial-out handshake bundle for shift_unbuffer.
interface shift_unbuffer_if;
  import buffer_pkg::*;

  vec_t  data_i;
  logic  data_valid_i;
  logic  data_ready_o;
  word_t data_o;
  logic  data_valid_o;
  logic  data_ready_i;
  logic  last_o;

  // slave: the serializer itself; master: the surrounding logic driving it
  modport slave (
    input  data_i, data_valid_i, data_ready_i,
    output data_ready_o, data_o, data_valid_o, last_o
  );

  modport master (
    output data_i, data_valid_i, data_ready_i,
    input  data_ready_o, data_o, data_valid_o, last_o
  );

endinterface

// File: rtl/vec_hold_reg.sv
// One-deep holding register with full flag; only built with SHIFT_UNBUFFER_PINGPONG_EN.
`ifdef SHIFT_UNBUFFER_PINGPONG_EN
module vec_hold_reg
  import buffer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  vec_t din,
  output vec_t dout,
  output logic full
);

  vec_t data_q;
  logic full_q;

  // push and pop are never asserted together by the owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (push) begin
      data_q <= din;
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule
`endif

// File: rtl/shift_unbuffer.sv
// 256-bit vector to 32-bit word serializer, word 0 (LSBs) first.
// SHIFT_UNBUFFER_PINGPONG_EN adds a holding vector for gap-free back-to-back output.
module shift_unbuffer
  import buffer_pkg::*;
(
  input logic             clk_data,
  input logic             rst_n,
  shift_unbuffer_if.slave bus
);

`ifdef SHIFT_UNBUFFER_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif

  unbuf_state_e     state_q, state_n;
  vec_t             shift_q, shift_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic             valid_q, valid_n;
  logic             last_q, last_n;
  logic             ready_q, ready_n;

  logic in_hs, out_hs, is_last, load_en;
  vec_t load_vec;
  logic hold_push, hold_pop, hold_full, hold_full_n;
  vec_t hold_vec;

  assign in_hs   = bus.data_valid_i & ready_q;
  assign out_hs  = valid_q & bus.data_ready_i;
  assign is_last = (count_q == CNT_W'(WORDS - 1));

`ifdef SHIFT_UNBUFFER_PINGPONG_EN
  vec_hold_reg u_hold (
    .clk   (clk_data),
    .rst_n (rst_n),
    .push  (hold_push),
    .pop   (hold_pop),
    .din   (bus.data_i),
    .dout  (hold_vec),
    .full  (hold_full)
  );
`else
  logic unused_hold;
  assign hold_full   = 1'b0;
  assign hold_vec    = '0;
  assign unused_hold = ^{hold_push, hold_pop, hold_full_n};
`endif

  // Next-state: load on accept, shift on each output handshake
  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    count_n   = count_q;
    valid_n   = valid_q;
    last_n    = last_q;
    load_en   = 1'b0;
    load_vec  = bus.data_i;
    hold_push = 1'b0;
    hold_pop  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_hs) load_en = 1'b1;
      end
      SEND: begin
        if (out_hs && is_last) begin
          if (hold_full) begin
            load_en  = 1'b1;
            load_vec = hold_vec;
            hold_pop = 1'b1;
          end else if (in_hs) begin
            load_en = 1'b1;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
            shift_n = shift_q >> DATA_W;
          end
        end else begin
          if (out_hs) begin
            shift_n = shift_q >> DATA_W;
            count_n = count_q + CNT_W'(1);
            last_n  = (count_q == CNT_W'(WORDS - 2));
          end
          // only reachable when the holding register exists
          if (in_hs) hold_push = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load_en) begin
      shift_n = load_vec;
      count_n = '0;
      state_n = SEND;
      valid_n = 1'b1;
      last_n  = (WORDS == 1);
    end

    hold_full_n = hold_push | (hold_full & ~hold_pop);
    ready_n     = PINGPONG ? ~hold_full_n : (state_n == IDLE);
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_n;
      shift_q <= shift_n;
      count_q <= count_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      ready_q <= ready_n;
    end
  end

  assign bus.data_o       = shift_q[DATA_W-1:0];
  assign bus.data_valid_o = valid_q;
  assign bus.last_o       = last_q;
  assign bus.data_ready_o = ready_q;

endmodule

// File: tb/tb_shift_unbuffer.sv
// Scoreboard bench for shift_unbuffer; expectations follow SHIFT_UNBUFFER_PINGPONG_EN.
module tb_shift_unbuffer;
  import buffer_pkg::*;

`ifdef SHIFT_UNBUFFER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  typedef struct packed {
    word_t data;
    logic  last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_unbuffer_if ifc ();

  shift_unbuffer dut (
    .clk_data (clk),
    .rst_n    (rst_n),
    .bus      (ifc.slave)
  );

  exp_t exp_q[$];
  vec_t vec_q[$];
  int   hs_cycles[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   words_seen = 0;
  int   acc_cyc = 0;
  vec_t asm_vec = '0;
  logic ready_val = 1'b1;
  bit   bp_rand = 1'b0;

  task automatic chk(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk_vec(input int base);
    vec_t v;
    for (int k = 0; k < WORDS; k++) v[k*DATA_W +: DATA_W] = word_t'(base + k);
    return v;
  endfunction

  task automatic push_vec(input vec_t v);
    exp_t e;
    for (int k = 0; k < WORDS; k++) begin
      e.data = v[k*DATA_W +: DATA_W];
      e.last = (k == WORDS - 1);
      exp_q.push_back(e);
    end
    vec_q.push_back(v);
  endtask

  always @(posedge clk) cyc++;

  // Downstream ready: fixed value or random backpressure
  initial begin
    ifc.data_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ifc.data_ready_i = bp_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Monitor: word scoreboard plus a shift_buffer-style reassembly model
  always @(negedge clk) begin : mon
    exp_t e;
    vec_t nv;
    if (rst_n === 1'b1 && ifc.data_valid_o === 1'b1 && ifc.data_ready_i === 1'b1) begin
      words_seen++;
      hs_cycles.push_back(cyc + 1);
      if (exp_q.size() == 0) begin
        chk("extra_word_valid", VEC_W'(ifc.data_valid_o), VEC_W'(0));
      end else begin
        e = exp_q.pop_front();
        chk("word", VEC_W'(ifc.data_o), VEC_W'(e.data));
        chk("last", VEC_W'(ifc.last_o), VEC_W'(e.last));
      end
      nv = {ifc.data_o, asm_vec[VEC_W-1:DATA_W]};
      asm_vec = nv;
      if (ifc.last_o === 1'b1) begin
        if (vec_q.size() == 0) chk("extra_vec_last", VEC_W'(ifc.last_o), VEC_W'(0));
        else chk("loopback_vec", nv, vec_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_vec(input vec_t v);
    bit done = 1'b0;
    ifc.data_i = v;
    ifc.data_valid_i = 1'b1;
    for (int b = 0; b < 300 && !done; b++) begin
      @(negedge clk);
      if (ifc.data_ready_o === 1'b1) begin
        push_vec(v);
        acc_cyc = cyc + 1;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    ifc.data_valid_i = 1'b0;
    if (!done) chk("accept_timeout", VEC_W'(done), VEC_W'(1));
  endtask

  task automatic offer_once(input vec_t v, output bit acc);
    ifc.data_i = v;
    ifc.data_valid_i = 1'b1;
    @(negedge clk);
    acc = (ifc.data_ready_o === 1'b1);
    if (acc) push_vec(v);
    @(posedge clk);
    #1;
    ifc.data_valid_i = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 600) begin
      @(posedge clk);
      b++;
    end
    chk("drain_left", VEC_W'(exp_q.size()), VEC_W'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int target, input string tag);
    int b = 0;
    while (words_seen < target && b < 200) begin
      @(posedge clk);
      b++;
    end
    chk(tag, VEC_W'(words_seen >= target), VEC_W'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int a1, a2, base, ws;
    bit acc;
    rst_n = 1'b0;
    ifc.data_valid_i = 1'b0;
    ifc.data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", VEC_W'(ifc.data_ready_o), VEC_W'(1));
    chk("rst_valid", VEC_W'(ifc.data_valid_o), VEC_W'(0));
    chk("rst_data", VEC_W'(ifc.data_o), VEC_W'(0));
    chk("rst_last", VEC_W'(ifc.last_o), VEC_W'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: straight serialization with timing
    hs_cycles.delete();
    send_vec(mk_vec(10));
    a1 = acc_cyc;
    drain();
    chk("t1_count", VEC_W'(hs_cycles.size()), VEC_W'(8));
    for (int k = 0; k < hs_cycles.size(); k++) chk("t1_cycle", VEC_W'(hs_cycles[k]), VEC_W'(a1 + 1 + k));
    chk("t1_ready_back", VEC_W'(ifc.data_ready_o), VEC_W'(1));
    chk("t1_valid_low", VEC_W'(ifc.data_valid_o), VEC_W'(0));

    // 2: four-cycle stall on word 13
    base = words_seen;
    send_vec(mk_vec(10));
    wait_words(base + 3, "t2_reach_13");
    ready_val = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t2_hold_data", VEC_W'(ifc.data_o), VEC_W'(13));
      chk("t2_hold_valid", VEC_W'(ifc.data_valid_o), VEC_W'(1));
      chk("t2_hold_last", VEC_W'(ifc.last_o), VEC_W'(0));
    end
    ready_val = 1'b1;
    @(posedge clk);
    #1;
    drain();
    chk("t2_words", VEC_W'(words_seen - base), VEC_W'(8));

    // 3: back-to-back vectors
    hs_cycles.delete();
    send_vec(mk_vec(20));
    a1 = acc_cyc;
    send_vec(mk_vec(30));
    a2 = acc_cyc;
    drain();
    chk("t3_accept2", VEC_W'(a2), VEC_W'(PP ? a1 + 1 : a1 + 9));
    chk("t3_count", VEC_W'(hs_cycles.size()), VEC_W'(16));
    for (int k = 0; k < hs_cycles.size(); k++)
      chk("t3_cycle", VEC_W'(hs_cycles[k]), VEC_W'(a1 + 1 + k + ((k >= 8 && !PP) ? 1 : 0)));

    // 4: offer while word 22 is in flight
    base = words_seen;
    send_vec(mk_vec(20));
    wait_words(base + 2, "t4_reach_22");
    #1;
    offer_once(mk_vec(40), acc);
    chk("t4_accept", VEC_W'(acc), VEC_W'(PP));
    drain();

    // 5: reset mid-vector after word 12
    base = words_seen;
    send_vec(mk_vec(10));
    wait_words(base + 3, "t5_reach_12");
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", VEC_W'(ifc.data_valid_o), VEC_W'(0));
    chk("t5_data", VEC_W'(ifc.data_o), VEC_W'(0));
    chk("t5_last", VEC_W'(ifc.last_o), VEC_W'(0));
    chk("t5_ready", VEC_W'(ifc.data_ready_o), VEC_W'(1));
    exp_q.delete();
    vec_q.delete();
    ws = words_seen;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("t5_no_words", VEC_W'(words_seen), VEC_W'(ws));
    #1;
    send_vec(mk_vec(50));
    drain();

    // 6: random vectors under random backpressure
    bp_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      vec_t v;
      for (int k = 0; k < WORDS; k++) v[k*DATA_W +: DATA_W] = $urandom();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send_vec(v);
    end
    bp_rand = 1'b0;
    drain();
    chk("t6_vec_left", VEC_W'(vec_q.size()), VEC_W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
